pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register for a multi-lane datapath.
// Carries valid/pc/insn/ctrl/data from one stage to the next. Supports
// stall (hold), flush (insert a bubble) and a global write enable. Two
// saturating counters track stall cycles and bubbles entering the stage.
// Every output comes straight from a flop.
module pipe_stage_reg #(
    parameter int          DW       = 16,
    parameter int          NLANE    = 4,
    parameter int          CW       = 12,
    parameter logic [15:0] NOP_INSN = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [15:0]           pc_i,
    input  logic [15:0]           insn_i,
    input  logic [CW-1:0]         ctrl_i,
    input  logic [NLANE*DW-1:0]   data_i,
    output logic                  valid_o,
    output logic [15:0]           pc_o,
    output logic [15:0]           insn_o,
    output logic [CW-1:0]         ctrl_o,
    output logic [NLANE*DW-1:0]   data_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-edge action decode; flush beats stall, stall beats load.
    logic do_flush;
    logic do_stall;
    logic do_load;
    logic bubble_in;

    // Decode which of flush/stall/load applies on the coming edge.
    always_comb begin
        do_flush  = 1'b0;
        do_stall  = 1'b0;
        do_load   = 1'b0;
        bubble_in = 1'b0;
        if (gwe) begin
            if (flush_i) begin
                do_flush  = 1'b1;
                bubble_in = 1'b1;
            end else if (stall_i) begin
                do_stall  = 1'b1;
            end else begin
                do_load   = 1'b1;
                bubble_in = ~valid_i;
            end
        end
    end

    // Stage contents: reset clears, flush bubbles (keeping pc), load captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            pc_o    <= 16'h0000;
            insn_o  <= NOP_INSN;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (do_flush) begin
            valid_o <= 1'b0;
            insn_o  <= NOP_INSN;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (do_load) begin
            valid_o <= valid_i;
            pc_o    <= pc_i;
            data_o  <= data_i;
            if (valid_i) begin
                insn_o <= insn_i;
                ctrl_o <= ctrl_i;
            end else begin
                insn_o <= NOP_INSN;
                ctrl_o <= '0;
            end
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (do_stall && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end

    // Bubble counter (flushes and invalid loads), saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_o <= '0;
        end else if (bubble_in && (bubble_cnt_o != CNT_MAX)) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
    end

endmodule
